// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus: instruction memory request/ack plus the
// opcode handshake toward the decoder and the redirect input.
interface instruction_fetch_if;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_rdata;
   logic [7:0]  opcode;
   logic        opcode_valid;
   logic        opcode_ready;
   logic [15:0] opcode_pc;
   logic        redirect;
   logic [15:0] redirect_addr;

   modport master (
      output mem_req, mem_addr, opcode, opcode_valid, opcode_pc,
      input  mem_ack, mem_rdata, opcode_ready, redirect, redirect_addr
   );

   modport slave (
      input  mem_req, mem_addr, opcode, opcode_valid, opcode_pc,
      output mem_ack, mem_rdata, opcode_ready, redirect, redirect_addr
   );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: one outstanding byte read, shift-register
// opcode buffer, redirect flush with priority over everything.
module instruction_fetch #(
   parameter logic [15:0] RESET_VECTOR = 16'h0000,
   parameter int          FIFO_DEPTH   = 2
) (
   input logic                 clk,
   input logic                 rst_n,
   instruction_fetch_if.master bus
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   localparam logic [0:0] ST_STALL = 1'b0;
   localparam logic [0:0] ST_FETCH = 1'b1;

   typedef struct packed {
      logic [7:0]  op;
      logic [15:0] pc;
   } fq_entry_t;

   logic [0:0]  state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [CW-1:0] count_q, count_d;
   logic        valid_q, valid_d;
   fq_entry_t   ent_q [FIFO_DEPTH];
   fq_entry_t   ent_d [FIFO_DEPTH];

   logic        push;
   logic        pop;
   logic [CW-1:0] cnt_pop;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      count_d = count_q;
      ent_d   = ent_q;
      push    = 1'b0;
      pop     = 1'b0;
      cnt_pop = count_q;
      if (bus.redirect) begin
         count_d = '0;
         pc_d    = bus.redirect_addr;
         state_d = ST_FETCH;
      end else begin
         push    = (state_q == ST_FETCH) && bus.mem_ack;
         pop     = valid_q && bus.opcode_ready;
         cnt_pop = count_q - CW'(pop);
         // Head is always slot 0 so opcode/opcode_pc come straight off flops
         if (pop) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
               ent_d[i] = ent_q[i+1];
            end
         end
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (push && (CW'(i) == cnt_pop)) begin
               ent_d[i].op = bus.mem_rdata;
               ent_d[i].pc = pc_q;
            end
         end
         count_d = cnt_pop + CW'(push);
         if (push) begin
            pc_d = pc_q + 16'd1;
         end
         state_d = (count_d < CW'(FIFO_DEPTH)) ? ST_FETCH : ST_STALL;
      end
      valid_d = (count_d != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_STALL;
         pc_q    <= RESET_VECTOR;
         count_q <= '0;
         valid_q <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            ent_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         count_q <= count_d;
         valid_q <= valid_d;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            ent_q[i] <= ent_d[i];
         end
      end
   end

   assign bus.mem_req      = state_q[0];
   assign bus.mem_addr     = pc_q;
   assign bus.opcode       = ent_q[0].op;
   assign bus.opcode_pc    = ent_q[0].pc;
   assign bus.opcode_valid = valid_q;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The module SHALL have parameter RESET_VECTOR, default 16'h0000, the first fetch address after reset.
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 2, the opcode buffer depth; only the value 2 is required.
REQ-003 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: mem_req  output  1  instruction memory read request.
REQ-007 Port: mem_addr  output  16  fetch address; valid while mem_req=1.
REQ-008 Port: mem_ack  input  1  memory accepted the request; mem_rdata is valid in the same cycle.
REQ-009 Port: mem_rdata  input  8  fetched opcode byte.
REQ-010 Port: opcode  output  8  head-of-buffer opcode to the instruction decoder.
REQ-011 Port: opcode_valid  output  1  opcode and opcode_pc are valid.
REQ-012 Port: opcode_ready  input  1  decoder consumes the head entry this cycle.
REQ-013 Port: opcode_pc  output  16  fetch address of the head opcode.
REQ-014 Port: redirect  input  1  branch/jump taken; flush and refetch.
REQ-015 Port: redirect_addr  input  16  new fetch address; sampled when redirect=1.

Function
REQ-016 The FSM SHALL have two states: FETCH (mem_req=1) and STALL (mem_req=0).
REQ-017 mem_req, mem_addr, opcode, opcode_valid and opcode_pc SHALL all be driven from registers.
REQ-018 While mem_req=1 and mem_ack=0, mem_addr SHALL be held stable.
REQ-019 On mem_ack=1 with mem_req=1 and redirect=0: {mem_rdata, mem_addr} SHALL be pushed into the buffer.
REQ-020 On the same accepted ack, the fetch PC SHALL be incremented modulo 2^16, so 16'hFFFF wraps to 16'h0000.
REQ-021 Only one request SHALL ever be outstanding.
REQ-022 After an ack, the FSM SHALL remain in FETCH at the next address when post-update occupancy is less than FIFO_DEPTH; otherwise it SHALL go to STALL.
REQ-023 STALL SHALL go to FETCH in the cycle after occupancy drops below FIFO_DEPTH.
REQ-024 The buffer SHALL be a FIFO of {opcode, pc} entries.
REQ-025 A pop SHALL occur when opcode_valid=1 and opcode_ready=1.
REQ-026 A simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
REQ-027 A push SHALL never occur when the buffer is full; REQ-022 guarantees this.
REQ-028 A pop SHALL never occur when the buffer is empty; opcode_valid=0 then.
REQ-029 Latency: an ack in cycle N into an empty buffer SHALL give opcode_valid=1 in cycle N+1, with opcode equal to the acked mem_rdata.
REQ-030 On redirect=1 in cycle N: the buffer SHALL be flushed and any mem_ack in cycle N SHALL be ignored.
REQ-031 After a redirect in cycle N: opcode_valid=0 in cycle N+1; mem_req=1 and mem_addr=redirect_addr in cycle N+1; state=FETCH.
REQ-032 Redirect SHALL take priority over push, pop and the stall logic.
REQ-033 Memory SHALL tolerate a request withdrawn without ack; mem_ack is meaningful only while mem_req=1.
REQ-034 opcode_ready while opcode_valid=0 SHALL have no effect.
REQ-035 opcode and opcode_pc SHALL be held stable while opcode_valid=1 and opcode_ready=0.

Reset
REQ-036 On rst_n=0 the block SHALL asynchronously clear to the following values:
- mem_req=0
- mem_addr=RESET_VECTOR
- opcode=8'h00
- opcode_pc=16'h0000
- opcode_valid=0
- buffer empty
- fetch PC=RESET_VECTOR
- state=STALL
REQ-037 On the first rising edge after rst_n deasserts, the block SHALL enter FETCH, driving mem_req=1 and mem_addr=RESET_VECTOR.
REQ-038 Reset asserted mid-request SHALL abandon the request; a later ack SHALL be ignored because mem_req=0.

Verification
REQ-039 Reset release, single-cycle acks, data 8'h01, 8'h02 at 0000, 0001, opcode_ready=1 -> opcode_valid rises one cycle after the first ack; decoder sees 8'h01/pc 0000, then 8'h02/pc 0001.
REQ-040 opcode_ready=0, acks every cycle -> exactly 2 pushes; mem_req drops to 0 and mem_addr=0002 is held; raising opcode_ready for one cycle -> mem_req=1 at 0002 the next cycle.
REQ-041 Buffer full (8'h01, 8'h02), redirect=1 with redirect_addr=16'h1234 while mem_ack=1 with data 8'hAA -> next cycle opcode_valid=0, mem_req=1, mem_addr=1234; 8'hAA is never presented.
REQ-042 Jump to 16'hFFFF, ack data 8'h08 then 8'h09 -> opcode_pc FFFF then 0000.
REQ-043 mem_ack held low 5 cycles with mem_req=1 -> mem_addr stable throughout, opcode_valid=0; ack then gives opcode_valid=1 on the next cycle.
REQ-044 rst_n pulsed low mid-request with buffer holding 1 entry -> all outputs at reset values immediately; after release, fetch restarts at RESET_VECTOR.
